dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 85 ++++++++
 tb/tb_dmem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state, wait-counter width, request record and address check for dmem_responder.
package dmem_pkg;
  localparam int DATA_W = 32;
  localparam int BE_W = DATA_W / 8;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;
  function automatic logic addr_err(input logic [DATA_W-1:0] a, input int depth);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DATA_W'(depth));
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with byte-masked synchronous write and registered synchronous read.
module dmem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [AW-1:0]      addr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] be,
  output logic [WIDTH-1:0]   rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;
  always_comb rdata_d = re ? mem[addr] : rdata_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH / 8; i++)
      if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready load/store responder with WAIT_STATES fixed latency over dmem_array.
// Define DMEM_BE_EN to add the req_be port and per-byte store enables.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
`ifdef DMEM_BE_EN
  input  logic [WIDTH/8-1:0] req_be,
`endif
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err
);
  localparam int AW = $clog2(DEPTH);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic             accept, enter_resp, acc_err, mem_we, mem_re;
  logic [WIDTH-1:0] mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    accept = state_q == IDLE && req_valid;
    req_d  = req_q;
    if (accept) begin
      req_d.write = req_write;
      req_d.addr  = DATA_W'(req_addr);
      req_d.wdata = DATA_W'(req_wdata);
`ifdef DMEM_BE_EN
      req_d.be    = BE_W'(req_be);
`else
      req_d.be    = '1;
`endif
    end
    cnt_d = accept ? CNT_W'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1)
          : state_q == WAIT ? cnt_q - 1'b1 : cnt_q;
    state_d = state_q == IDLE ? (req_valid ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE)
            : state_q == WAIT ? (cnt_q == '0 ? RESP : WAIT)
            : (rsp_ready ? IDLE : RESP);
  end

  // The array is touched only on the edge that enters RESP; req_d already holds the request then.
  always_comb begin
    enter_resp = state_d == RESP && state_q != RESP && !reset;
    acc_err    = addr_err(req_d.addr, DEPTH);
    mem_we     = enter_resp && req_d.write && !acc_err;
    mem_re     = enter_resp && !req_d.write && !acc_err;
    req_ready  = state_q == IDLE;
    rsp_valid  = state_q == RESP;
    rsp_err    = rsp_valid && addr_err(req_q.addr, DEPTH);
    rsp_rdata  = (rsp_valid && !req_q.write && !rsp_err) ? mem_rdata : '0;
  end

  dmem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (req_d.addr[AW+1:2]),
    .wdata (WIDTH'(req_d.wdata)),
    .be    (req_d.be[WIDTH/8-1:0]),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a transaction-level model.
module tb_dmem_responder;
  localparam int W = 2;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_write = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_be = 4'hF;
  logic        req_ready, rsp_valid, rsp_err, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rnd_rdy = 0, rdy_force = 1, rnd_bit = 1;
  assign rsp_ready = rnd_rdy ? rnd_bit : rdy_force;
  always @(negedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

  logic        z_req_valid = 0, z_req_write = 0;
  logic [31:0] z_req_addr = 0, z_req_wdata = 0;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  dmem_responder #(.WIDTH(32), .DEPTH(1024), .WAIT_STATES(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BE_EN
    .req_be(req_be),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dut_z (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
`ifdef DMEM_BE_EN
    .req_be(4'hF),
`endif
    .rsp_valid(z_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err));

  int n_cmp = 0, n_bad = 0;
  bit chk_on = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  // Transaction model: a response becomes visible W+1 cycles after acceptance and the memory effect
  // happens at that moment; a handshake retires it and the responder is free again one cycle later.
  bit          pend = 0, exp_err = 0;
  longint      cyc = 0, vis_at = 0;
  logic        m_w;
  logic [31:0] m_a, m_d, exp_rdata;
  logic [3:0]  m_be;
  logic [31:0] mm [1024];

  always @(posedge clk or posedge reset) begin
    if (reset) pend = 0;
    else begin
      if (pend && cyc >= vis_at) begin
        if (rsp_ready) pend = 0;
      end else if (!pend && req_valid) begin
        pend = 1; vis_at = cyc + W + 1;
        m_w = req_write; m_a = req_addr; m_d = req_wdata; m_be = req_be;
      end
      cyc++;
      if (pend && cyc == vis_at) begin
        exp_err = (m_a % 4 != 0) || (m_a / 4 >= 1024);
        exp_rdata = 0;
        if (!exp_err && m_w) begin
`ifdef DMEM_BE_EN
          for (int b = 0; b < 4; b++) if (m_be[b]) mm[m_a / 4][b*8 +: 8] = m_d[b*8 +: 8];
`else
          mm[m_a / 4] = m_d;
`endif
        end else if (!exp_err) exp_rdata = mm[m_a / 4];
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    check("req_ready", 32'(req_ready), 32'(!pend));
    check("rsp_valid", 32'(rsp_valid), 32'(pend && cyc >= vis_at));
    if (pend && cyc >= vis_at) begin
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bit ok = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (req_ready) ok = 1;
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 0, 1);
    req_valid = 0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic e, output int lat);
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
    d = rsp_rdata; e = rsp_err;
  endtask

  task automatic xfer(input string nm, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] ed, input bit ee);
    logic [31:0] rd;
    logic re;
    int lat;
    issue(w, a, d, be);
    wait_rsp(rd, re, lat);
    check({nm, "_lat"}, 32'(lat), 32'(W + 1));
    check({nm, "_rdata"}, rd, ed);
    check({nm, "_err"}, 32'(re), 32'(ee));
    @(negedge clk);
  endtask

  task automatic rst_pulse(input string nm);
    #2 reset = 1;
    #1;
    check({nm, "_valid"}, 32'(rsp_valid), 0);
    check({nm, "_rdata"}, rsp_rdata, 0);
    check({nm, "_err"}, 32'(rsp_err), 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check({nm, "_ready"}, 32'(req_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    logic re;
    int lat, r, idx;
    #2 reset = 1; chk_on = 1;
    #1;
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_rdata", rsp_rdata, 0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 1);
    for (int i = 0; i < 16; i++)
      xfer("preload", 1, 32'(i * 4), 32'h600D_0000 | 32'(i * 32'h111), 4'hF, 0, 0);

    xfer("st_10", 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    xfer("ld_10", 0, 32'h10, 0, 4'hF, 32'hDEAD_BEEF, 0);
    xfer("ld_mis", 0, 32'h13, 0, 4'hF, 0, 1);
    xfer("st_oor", 1, 32'h1000, 32'hBAD0_BAD0, 4'hF, 0, 1);
    xfer("ld_0", 0, 32'h0, 0, 4'hF, 32'h600D_0000, 0);

    rdy_force = 0;
    issue(0, 32'h10, 0, 4'hF);
    wait_rsp(rd, re, lat);
    check("hold_lat", 32'(lat), 3);
    req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'h0BAD_F00D;
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("hold_err", 32'(rsp_err), 0);
      check("hold_ready", 32'(req_ready), 0);
    end
    req_valid = 0; rdy_force = 1;
    @(negedge clk);
    check("hold_release_ready", 32'(req_ready), 1);
    xfer("ld_after_hold", 0, 32'h10, 0, 4'hF, 32'hDEAD_BEEF, 0);

    xfer("st_20", 1, 32'h20, 32'hAAAA_AAAA, 4'hF, 0, 0);
    issue(1, 32'h20, 32'h1234_5678, 4'hF);
    check("wait_no_valid", 32'(rsp_valid), 0);
    rst_pulse("rst_wait");
    xfer("ld_20", 0, 32'h20, 0, 4'hF, 32'hAAAA_AAAA, 0);
    rdy_force = 0;
    issue(0, 32'h10, 0, 4'hF);
    wait_rsp(rd, re, lat);
    check("resp_pre_rst", rd, 32'hDEAD_BEEF);
    rst_pulse("rst_resp");
    issue(0, 32'h13, 0, 4'hF);
    wait_rsp(rd, re, lat);
    check("err_pre_rst", 32'(re), 1);
    rst_pulse("rst_err");
    rdy_force = 1;

    xfer("st_30", 1, 32'h30, 32'h1122_3344, 4'hF, 0, 0);
    xfer("st_30_be", 1, 32'h30, 32'hAABB_CCDD, 4'b0101, 0, 0);
`ifdef DMEM_BE_EN
    xfer("ld_30_be", 0, 32'h30, 0, 4'hF, 32'h11BB_33DD, 0);
    xfer("st_30_be0", 1, 32'h30, 32'h5555_5555, 4'b0000, 0, 0);
    xfer("ld_30_be0", 0, 32'h30, 0, 4'hF, 32'h11BB_33DD, 0);
`else
    xfer("ld_30_full", 0, 32'h30, 0, 4'hF, 32'hAABB_CCDD, 0);
`endif

    rnd_rdy = 1;
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      idx = $urandom_range(0, 15);
      a = r < 7 ? 32'(idx * 4) : r < 8 ? 32'(idx * 4 + $urandom_range(1, 3))
        : 32'h1000 + 32'(idx * 4) + (r == 9 ? 32'h4000_0000 : 32'h0);
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rnd_rdy = 0; rdy_force = 1;
    repeat (10) @(negedge clk);
    check("drained", 32'(req_ready), 1);

    z_req_write = 1; z_req_addr = 32'h4; z_req_wdata = 32'hCAFE_F00D; z_req_valid = 1;
    for (int i = 0; i < 10; i++) begin
      check("z_req_ready", 32'(z_req_ready), 32'(i % 2 == 0));
      check("z_rsp_valid", 32'(z_rsp_valid), 32'(i % 2 == 1));
      if (i % 2 == 1) begin
        check("z_rsp_rdata", z_rsp_rdata, i == 1 ? 32'h0 : 32'hCAFE_F00D);
        check("z_rsp_err", 32'(z_rsp_err), 0);
      end
      if (i == 1) z_req_write = 0;
      @(negedge clk);
    end
    z_req_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
